// File: rtl/ahb_sram_slv_if.sv
// AHB-lite bus bundle between a master (or fabric) and ahb_sram_slv.
// hready is the fabric-level ready fed back to every slave.
interface ahb_sram_slv_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [3:0]            hprot;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hready;
  logic                  hreadyout;
  logic [1:0]            hresp;
  logic [DATA_WIDTH-1:0] hrdata;

  modport master (
    output hsel,
    output haddr,
    output htrans,
    output hwrite,
    output hsize,
    output hburst,
    output hprot,
    output hwdata,
    output hready,
    input  hreadyout,
    input  hresp,
    input  hrdata
  );

  modport slave (
    input  hsel,
    input  haddr,
    input  htrans,
    input  hwrite,
    input  hsize,
    input  hburst,
    input  hprot,
    input  hwdata,
    input  hready,
    output hreadyout,
    output hresp,
    output hrdata
  );
endinterface

// File: rtl/ahb_sram_slv.sv
// AHB slave in front of a word-addressed SRAM with wait states.
// Define AHB_SRAM_SLV_ERR_RESP_EN for two-cycle ERROR responses.
module ahb_sram_slv #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic           hclk,
  input logic           hreset,
  ahb_sram_slv_if.slave bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int XW = ADDR_WIDTH - 2;
  localparam logic [XW-1:0] DEPTH_W = XW'(DEPTH);
  localparam logic [3:0] WS    = WAIT_STATES[3:0];
  localparam logic [3:0] WS_M1 = WS - 4'd1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    ERR1,
    ERR2
  } state_t;

  typedef struct packed {
    logic          wr;
    logic [3:0]    mask;
    logic [IW-1:0] idx;
  } aph_t;

  state_t state_q, state_d;
  aph_t   aph_q, aph_d;
  logic [3:0] cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rd_word;

  logic          accept;
  logic          done;
  logic          take;
  logic          err_xfer;
  logic [XW-1:0] widx_full;
  logic [XW-1:0] widx_mod;
  logic [IW-1:0] widx;
  logic [3:0]    mask;
  logic          rd_en;
  logic [IW-1:0] rd_idx;
  logic          wr_en;
  logic          unused_ok;

  assign unused_ok = ^{bus.hburst, bus.hprot,
                       bus.htrans[0], widx_mod};

  assign widx_full = bus.haddr[ADDR_WIDTH-1:2];
  assign widx_mod  = widx_full % DEPTH_W;
  assign widx      = widx_mod[IW-1:0];

  // Lane decode; misaligned half/word land on the aligned lanes
  always_comb begin
    mask = 4'b1111;
    unique case (1'b1)
      bus.hsize == 3'd0:
        mask = 4'b0001 << bus.haddr[1:0];
      bus.hsize == 3'd1:
        mask = bus.haddr[1] ? 4'b1100 : 4'b0011;
      default:
        mask = 4'b1111;
    endcase
  end

`ifdef AHB_SRAM_SLV_ERR_RESP_EN
  always_comb begin
    err_xfer = 1'b0;
    unique case (1'b1)
      widx_full >= DEPTH_W:
        err_xfer = 1'b1;
      bus.hsize > 3'd2:
        err_xfer = 1'b1;
      bus.hsize == 3'd2:
        err_xfer = bus.haddr[1:0] != 2'b00;
      bus.hsize == 3'd1:
        err_xfer = bus.haddr[0];
      default:
        err_xfer = 1'b0;
    endcase
  end
`else
  assign err_xfer = 1'b0;
`endif

  assign accept = bus.hsel & bus.hready & bus.htrans[1];
  assign done   = (state_q == DATA) && (cnt_q == WS);
  assign take   = accept && ((state_q == IDLE) || done);
  assign wr_en  = done && aph_q.wr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    aph_d   = aph_q;
    unique case (state_q)
      IDLE, DATA: begin
        if (state_q == DATA && !done) begin
          cnt_d = cnt_q + 4'd1;
        end else if (take) begin
          state_d = err_xfer ? ERR1 : DATA;
          cnt_d   = '0;
          aph_d   = '{wr:   bus.hwrite,
                      mask: mask,
                      idx:  widx};
        end else begin
          state_d = IDLE;
        end
      end
      ERR1:    state_d = ERR2;
      ERR2:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      aph_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      aph_q   <= aph_d;
    end
  end

  // Zero-wait reads sample the array on the accepting edge;
  // otherwise on the edge closing the last wait cycle.
  always_comb begin
    if (WAIT_STATES == 0) begin
      rd_en  = take && !bus.hwrite && !err_xfer;
      rd_idx = widx;
    end else begin
      rd_en  = (state_q == DATA) && !aph_q.wr &&
               (cnt_q == WS_M1);
      rd_idx = aph_q.idx;
    end
  end

  always_comb begin
    rd_word = mem[rd_idx];
    for (int b = 0; b < 4; b++) begin
      if (wr_en && (aph_q.idx == rd_idx) &&
          aph_q.mask[b]) begin
        rd_word[8*b +: 8] = bus.hwdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= rd_word;
    end
  end

  always_ff @(posedge hclk) begin
    if (wr_en && !hreset) begin
      for (int b = 0; b < 4; b++) begin
        if (aph_q.mask[b]) begin
          mem[aph_q.idx][8*b +: 8] <=
            bus.hwdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.hreadyout = !((state_q == ERR1) ||
                           ((state_q == DATA) &&
                            (cnt_q != WS)));
  assign bus.hrdata = rdata_q;

`ifdef AHB_SRAM_SLV_ERR_RESP_EN
  assign bus.hresp = {1'b0, (state_q == ERR1) ||
                            (state_q == ERR2)};
`else
  assign bus.hresp = 2'b00;
`endif

endmodule

// File: tb/tb_ahb_sram_slv.sv
// Bench for ahb_sram_slv: zero-wait and 3-wait instances on one clock.
// Directed table, hand corner cases, random traffic vs a memory model.
module tb_ahb_sram_slv;
  localparam int DEP = 64;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    bit          has_exp;
    logic [31:0] exp;
    bit          err;
    int          gap;
  } txn_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  logic hclk = 1'b0;
  logic hreset = 1'b1;
  always #5 hclk = ~hclk;

  bit          sel = 1'b0;
  logic        hselr = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = '0;
  logic [31:0] hwdata = '0;
  logic        frc_low = 1'b0;

  ahb_sram_slv_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b0();
  ahb_sram_slv_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b1();

  assign b0.hsel   = hselr & ~sel;
  assign b1.hsel   = hselr & sel;
  assign b0.haddr  = haddr;
  assign b1.haddr  = haddr;
  assign b0.htrans = htrans;
  assign b1.htrans = htrans;
  assign b0.hwrite = hwrite;
  assign b1.hwrite = hwrite;
  assign b0.hsize  = hsize;
  assign b1.hsize  = hsize;
  assign b0.hburst = 3'd1;
  assign b1.hburst = 3'd1;
  assign b0.hprot  = 4'h3;
  assign b1.hprot  = 4'h3;
  assign b0.hwdata = hwdata;
  assign b1.hwdata = hwdata;
  assign b0.hready = b0.hreadyout & ~(frc_low & ~sel);
  assign b1.hready = b1.hreadyout & ~(frc_low & sel);

  ahb_sram_slv #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .DEPTH(DEP), .WAIT_STATES(0)
  ) u0 (
    .hclk(hclk), .hreset(hreset), .bus(b0.slave)
  );

  ahb_sram_slv #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .DEPTH(DEP), .WAIT_STATES(3)
  ) u1 (
    .hclk(hclk), .hreset(hreset), .bus(b1.slave)
  );

  wire        rdy   = sel ? b1.hready : b0.hready;
  wire [1:0]  resp  = sel ? b1.hresp : b0.hresp;
  wire [31:0] rdata = sel ? b1.hrdata : b0.hrdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [2][DEP];
  txn_t q[$];
  vec_t tbl[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h",
               nm, sel, act, exp);
    end
  endtask

  function automatic int idx_of(logic [31:0] a);
    return int'(a[31:2] % 30'(DEP));
  endfunction

  function automatic logic [3:0] lanes(logic [31:0] a,
                                       logic [2:0] s);
    if (s == 3'd0) return 4'b0001 << a[1:0];
    if (s == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic bit is_err(logic [31:0] a,
                                logic [2:0] s);
`ifdef AHB_SRAM_SLV_ERR_RESP_EN
    return (a[31:2] >= 30'(DEP)) ||
           (s == 3'd1 && a[0]) ||
           (s == 3'd2 && a[1:0] != 2'b00) ||
           (s > 3'd2);
`else
    return (a[0] & s[2]) & 1'b0;
`endif
  endfunction

  task automatic mwrite(input bit d, input txn_t t);
    logic [3:0] m;
    int i;
    m = lanes(t.addr, t.size);
    i = idx_of(t.addr);
    for (int b = 0; b < 4; b++)
      if (m[b]) model[d][i][8*b +: 8] = t.wdata[8*b +: 8];
  endtask

  task automatic push(input bit wr, input logic [31:0] a,
                      input logic [2:0] s,
                      input logic [31:0] wd, input bit he,
                      input logic [31:0] e, input int gap);
    txn_t t;
    t.wr = wr; t.addr = a; t.size = s; t.wdata = wd;
    t.has_exp = he; t.exp = e; t.gap = gap;
    t.err = is_err(a, s);
    q.push_back(t);
  endtask

  task automatic addv(input bit wr, input logic [31:0] a,
                      input logic [2:0] s,
                      input logic [31:0] wd,
                      input logic [31:0] e);
    vec_t v;
    v.wr = wr; v.addr = a; v.size = s;
    v.wdata = wd; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic drive_idle();
    hselr  = 1'($urandom % 2);
    htrans = 2'($urandom % 2);
    haddr  = $urandom;
    hwrite = 1'($urandom % 2);
    hsize  = 3'($urandom % 3);
  endtask

  task automatic complete(input bit d, input txn_t t,
                          input int lows);
    chk("wait_cycles", lows, t.err ? 1 : (d ? 3 : 0));
    chk("hresp", {30'd0, resp}, t.err ? 1 : 0);
    if (!t.err) begin
      if (t.wr) mwrite(d, t);
      else chk("hrdata", rdata, t.has_exp ? t.exp :
                         model[d][idx_of(t.addr)]);
    end
  endtask

  // Pipelined master: drives the queue through dut d
  task automatic run_q(input bit d);
    txn_t ap, dp;
    bit ap_v, dp_v, r, eb;
    int lows, gcnt, guard;
    ap_v = 0; dp_v = 0; lows = 0; gcnt = 0; guard = 0;
    sel = d;
    while ((q.size() > 0 || ap_v || dp_v) &&
           guard < 20000) begin
      @(negedge hclk);
      guard++;
      r  = rdy;
      eb = dp_v && dp.err;
      hwdata = $urandom;
      if (dp_v) begin
        if (!dp.err) hwdata = dp.wdata;
        if (!r) begin
          lows++;
          if (dp.err) chk("err1_hresp", {30'd0, resp}, 1);
          if (lows > 40) begin
            chk("data_phase_timeout", 0, 1);
            dp_v = 0;
          end
        end else begin
          complete(d, dp, lows);
          dp_v = 0;
        end
      end
      if (!ap_v && q.size() > 0 && !eb) begin
        if (gcnt < q[0].gap) gcnt++;
        else begin
          ap = q.pop_front();
          ap_v = 1;
          gcnt = 0;
        end
      end
      if (ap_v) begin
        hselr = 1; htrans = 2'd2; haddr = ap.addr;
        hwrite = ap.wr; hsize = ap.size;
      end else if (eb && r) begin
        // address phase during ERR2 must be dropped
        hselr = 1; htrans = 2'd2; haddr = 32'h3C;
        hwrite = 1; hsize = 3'd2;
      end else begin
        drive_idle();
      end
      if (ap_v && r) begin
        dp = ap; dp_v = 1; ap_v = 0; lows = 0;
      end
    end
    if (guard >= 20000) chk("run_q_timeout", 0, 1);
    @(negedge hclk);
    hselr = 0; htrans = 2'd0;
  endtask

  task automatic rnd_txn(input int n);
    logic [31:0] a;
    logic [2:0] s;
    int k;
    for (int i = 0; i < n; i++) begin
      s = 3'($urandom % 3);
      a = 32'($urandom % 16) * 4;
`ifdef AHB_SRAM_SLV_ERR_RESP_EN
      if (s == 3'd0) a[1:0] = 2'($urandom % 4);
      if (s == 3'd1) a[1] = 1'($urandom % 2);
      k = int'($urandom % 10);
      if (k == 0) a = a + 32'h100;
      if (k == 1) begin s = 3'd2; a[1:0] = 2'b10; end
`else
      k = 0;
      a[1:0] = 2'($urandom % 4);
      a = a + 32'($urandom % 4) * 256;
`endif
      push(1'($urandom % 2), a, s, $urandom, 0, 0,
           ($urandom % 3 == 0) ? 1 + k % 2 : 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    logic [31:0] h;
    int lows;

    addv(1, 32'h10, 3'd2, 32'hDEADBEEF, 0);
    addv(0, 32'h10, 3'd2, 0, 32'hDEADBEEF);
    addv(1, 32'h20, 3'd2, 32'h11223344, 0);
    addv(1, 32'h21, 3'd0, 32'h0000AA00, 0);
    addv(0, 32'h20, 3'd2, 0, 32'h1122AA44);
    addv(1, 32'h30, 3'd2, 32'hCAFEF00D, 0);
    addv(0, 32'h30, 3'd2, 0, 32'hCAFEF00D);
    addv(1, 32'h32, 3'd1, 32'h55660000, 0);
    addv(0, 32'h30, 3'd2, 0, 32'h5566F00D);
    addv(1, 32'h33, 3'd0, 32'h7F000000, 0);
    addv(0, 32'h30, 3'd2, 0, 32'h7F66F00D);
`ifdef AHB_SRAM_SLV_ERR_RESP_EN
    addv(1, 32'h100, 3'd2, 32'h0BADF00D, 0);
    addv(0, 32'h00, 3'd2, 0, 32'hA5000000);
    addv(1, 32'h01, 3'd1, 32'h0000FFFF, 0);
    addv(0, 32'h00, 3'd2, 0, 32'hA5000000);
    addv(0, 32'h100, 3'd2, 0, 0);
    addv(1, 32'h12, 3'd2, 32'h12121212, 0);
    addv(0, 32'h10, 3'd2, 0, 32'hDEADBEEF);
`else
    addv(1, 32'h104, 3'd2, 32'h0BADF00D, 0);
    addv(0, 32'h04, 3'd2, 0, 32'h0BADF00D);
    addv(1, 32'h13, 3'd1, 32'h77880000, 0);
    addv(0, 32'h10, 3'd2, 0, 32'h7788BEEF);
    addv(1, 32'h2B, 3'd2, 32'h01020304, 0);
    addv(0, 32'h28, 3'd2, 0, 32'h01020304);
`endif

    repeat (3) @(negedge hclk);
    hreset = 0;
    sel = 0;
    chk("rst_hreadyout", {31'd0, b0.hreadyout}, 1);
    chk("rst_hresp", {30'd0, b0.hresp}, 0);
    chk("rst_hrdata", b0.hrdata, 0);
    sel = 1;
    chk("rst_hreadyout", {31'd0, b1.hreadyout}, 1);
    chk("rst_hresp", {30'd0, b1.hresp}, 0);
    chk("rst_hrdata", b1.hrdata, 0);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i <= 16; i++)
        push(1, 32'(i * 4), 3'd2, 32'hA5000000 | 32'(i),
             0, 0, 0);
      run_q(1'(d));
      foreach (tbl[i])
        push(tbl[i].wr, tbl[i].addr, tbl[i].size,
             tbl[i].wdata, !tbl[i].wr &&
             !is_err(tbl[i].addr, tbl[i].size),
             tbl[i].exp, 0);
      run_q(1'(d));
    end

    // wait-state read; phases offered while hready is low
    sel = 1;
    @(negedge hclk);
    hselr = 1; htrans = 2'd2; hwrite = 0;
    haddr = 32'h10; hsize = 3'd2;
    lows = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge hclk);
      if (!rdy) begin
        lows++;
        hselr = 1; htrans = 2'd2; hwrite = 1;
        haddr = 32'h3C; hsize = 3'd2; hwdata = $urandom;
      end else begin
        chk("ws3_hrdata", rdata, model[1][4]);
        hselr = 0; htrans = 2'd0;
        break;
      end
    end
    chk("ws3_low_cycles", lows, 3);

    // forced hready low with no data phase
    sel = 0;
    @(negedge hclk);
    h = b0.hrdata;
    frc_low = 1;
    hselr = 1; htrans = 2'd2; hwrite = 1;
    haddr = 32'h38; hsize = 3'd2; hwdata = 32'hFFFFFFFF;
    repeat (2) begin
      @(negedge hclk);
      chk("hrdy_low_hreadyout", {31'd0, b0.hreadyout}, 1);
      chk("hrdy_low_hresp", {30'd0, b0.hresp}, 0);
    end
    frc_low = 0;
    hselr = 0; htrans = 2'd0;
    @(negedge hclk);
    chk("hrdata_hold", b0.hrdata, h);
    push(0, 32'h38, 3'd2, 0, 0, 0, 0);
    run_q(0);
    push(0, 32'h3C, 3'd2, 0, 0, 0, 0);
    run_q(1);

    // reset during the 2nd wait cycle of a write
    sel = 1;
    @(negedge hclk);
    hselr = 1; htrans = 2'd2; hwrite = 1;
    haddr = 32'h40; hsize = 3'd2;
    @(negedge hclk);
    hselr = 0; htrans = 2'd0; hwdata = 32'hFFFF0000;
    @(negedge hclk);
    hreset = 1;
    @(negedge hclk);
    hreset = 0;
    chk("midrst_hreadyout", {31'd0, b1.hreadyout}, 1);
    chk("midrst_hresp", {30'd0, b1.hresp}, 0);
    chk("midrst_hrdata", b1.hrdata, 0);
    push(0, 32'h40, 3'd2, 0, 1, 32'hA5000010, 0);
    run_q(1);

    for (int d = 0; d < 2; d++) begin
      rnd_txn(150);
      run_q(1'(d));
      for (int i = 0; i <= 16; i++)
        push(0, 32'(i * 4), 3'd2, 0, 0, 0, 0);
      run_q(1'(d));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb_sram_slv.md
Name: ahb_sram_slv

Overview:
- AHB slave responder fronting an on-chip word-addressed SRAM array; the opposite end of the master-driven AHB bus in our VIP environment.
- Decodes pipelined address/data phases, performs byte-lane writes and registered reads.
- Inserts a configurable number of wait states per transfer.
- Optional two-cycle ERROR response. Serves as the RTL DUT the AHB master agent and monitor run against.

Parameters:
- ADDR_WIDTH, 32, haddr width.
- DATA_WIDTH, 32, hrdata/hwdata width; only 32 supported.
- DEPTH, 1024, number of 32-bit words in the array.
- WAIT_STATES, 0, hreadyout-low cycles inserted in every OKAY data phase (0..15).

Ports:
- hclk  input  1  bus clock, all logic on rising edge
- hreset  input  1  synchronous active-high reset
- hsel  input  1  slave select
- haddr  input  ADDR_WIDTH  byte address
- htrans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hwrite  input  1  1=write
- hsize  input  3  0=byte, 1=half, 2=word
- hburst  input  3  burst type; accepted, no effect on behaviour
- hprot  input  4  protection; accepted, ignored
- hwdata  input  DATA_WIDTH  write data, valid in data phase
- hready  input  1  bus-level ready; address phase sampled only when high
- hreadyout  output  1  slave ready
- hresp  output  2  OKAY=0, ERROR=1
- hrdata  output  DATA_WIDTH  read data, valid when hreadyout=1 at end of read data phase

Behaviour:
- Reset (hreset high at posedge): hreadyout=1, hresp=0, hrdata=0, state=IDLE, pending write cleared, wait counter=0. Memory contents not reset.
- Reset mid-transfer aborts it: no write committed, outputs take reset values the next cycle.
- Address phase is accepted at posedge when hsel & hready & htrans[1]. It captures haddr, hwrite, hsize.
- IDLE/BUSY or hsel=0 with hready=1: the data phase that follows is zero-wait with hresp=OKAY.
- States:
  - IDLE: no active data phase.
  - DATA: counts WAIT_STATES cycles with hreadyout=0, then one cycle with hreadyout=1.
  - ERR1 and ERR2: see error response below.
- Transitions:
  - Accepted valid transfer -> DATA; accepted error transfer -> ERR1.
  - DATA completes at hreadyout=1. It returns to IDLE, or re-enters DATA/ERR1 if a new address phase is accepted in that same cycle (back-to-back pipelining).
- Latency:
  - WAIT_STATES=0: write data sampled from hwdata and committed at the posedge ending the data phase; read data on hrdata in the first data-phase cycle.
  - WAIT_STATES=N: hreadyout low N cycles, then high one cycle.
- Byte lanes: little-endian. Lane mask is derived from hsize and haddr[1:0]:
  - byte: lane haddr[1:0].
  - half: lanes {haddr[1],0}+{0,1}.
  - word: all lanes.
  - Unselected bytes are unchanged.
- Word index = haddr[ADDR_WIDTH-1:2] modulo DEPTH.
- hrdata is registered. The array read occurs at the posedge that accepts the read address phase, or at the last wait-cycle edge when WAIT_STATES>0.
- Read-after-write hazard: a write may be committing on the same edge as a read of the same word index. The lanes being written are forwarded from hwdata into hrdata; the other lanes come from the array.
- hrdata holds its last value outside read data phases.
- hready low with no active data phase: no new address phase sampled, outputs stable.

Optional Feature:
- Macro: AHB_SRAM_SLV_ERR_RESP_EN.
- Defined: a transfer is an error transfer if any of the following holds:
  - word index >= DEPTH (no wrap);
  - haddr is misaligned for hsize (half with haddr[0]=1, word with haddr[1:0]!=0);
  - hsize>2.
- Error transfers take the two-cycle response: ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1). No memory access, hrdata unchanged, WAIT_STATES not applied. An address phase presented during ERR2 is ignored.
- Not defined: no error checking. Index wraps modulo DEPTH, misaligned low address bits are forced to the size-aligned value, and hresp is constantly 0.

Test Plan:
- Word write 0x0000_0010 data 0xDEADBEEF, then read 0x10 -> hrdata=0xDEADBEEF, hresp=0, hreadyout never low (WAIT_STATES=0).
- Word write 0x20 data 0x11223344, byte write 0x21 data 0x0000AA00, read 0x20 -> 0x1122AA44.
- Back-to-back write 0x30 data 0xCAFEF00D, with the read of 0x30 in the next address phase -> hrdata=0xCAFEF00D (forwarded); same with half write 0x32 -> upper lanes forwarded only.
- WAIT_STATES=3, read 0x10 -> hreadyout low exactly 3 cycles, data valid on 4th; hready-low cycles ignore new phases.
- With ERR_RESP_EN, write to word index DEPTH and half access at 0x01 -> hreadyout 0 then 1 with hresp=1 both cycles, memory unchanged on readback.
- hreset asserted during the 2nd wait cycle of a write to 0x40 -> hreadyout=1, hresp=0, hrdata=0 next cycle; readback of 0x40 shows old value.
